// File: rtl/delay_array_if.sv
// delay_array_if: request and status signals of the delay_array timer bank.
// The master drives start/abort/lim/mode/ack; the slave (timer bank) drives the status outputs.
interface delay_array_if #(
  parameter int NCH   = 4,
  parameter int CBITS = 12
);
  logic [NCH-1:0]       start;
  logic [NCH-1:0]       abort;
  logic [NCH*CBITS-1:0] lim;
  logic [NCH-1:0]       mode;
  logic [NCH-1:0]       ack;
  logic [NCH-1:0]       sig;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       pend;
  logic [NCH-1:0]       err;
  logic                 idle_all;

  modport master (
    output start, abort, lim, mode, ack,
    input  sig, busy, pend, err, idle_all
  );

  modport slave (
    input  start, abort, lim, mode, ack,
    output sig, busy, pend, err, idle_all
  );
endinterface

// File: rtl/delay_array.sv
// delay_array: NCH independent one-shot/periodic delay timers with pend/ack event flags.
// Define DELAY_ARRAY_OVERRUN_EN to build the sticky per-channel overrun flags (err); otherwise err is tied to 0.
module delay_array #(
  parameter int NCH              = 4,
  parameter int CBITS            = 12,
  parameter bit PERIODIC_DEFAULT = 1'b0
) (
  input logic          clk,
  input logic          rst,
  delay_array_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [NCH-1:0] run_d;
  logic           idle_all_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [CBITS-1:0] lim_q, lim_d;
    logic             mode_q, mode_d;
    logic             fire;
    logic             sig_q;
    logic             pend_q;

    // Abort outranks start, and start outranks expiry, so a restart never emits a pulse.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lim_d   = lim_q;
      mode_d  = mode_q;
      fire    = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start[i] && !bus.abort[i]) begin
            state_d = RUN;
            cnt_d   = '0;
            lim_d   = bus.lim[i*CBITS +: CBITS];
            mode_d  = bus.mode[i];
          end
        end
        RUN: begin
          if (bus.abort[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (bus.start[i]) begin
            cnt_d  = '0;
            lim_d  = bus.lim[i*CBITS +: CBITS];
            mode_d = bus.mode[i];
          end else if (cnt_q == lim_q) begin
            fire    = 1'b1;
            cnt_d   = '0;
            state_d = mode_q ? RUN : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // NOTE: rst is synchronous, so it is tested inside the clocked branch and only acts on a rising edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        lim_q   <= '0;
        mode_q  <= PERIODIC_DEFAULT;
        sig_q   <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lim_q   <= lim_d;
        mode_q  <= mode_d;
        sig_q   <= fire;
        pend_q  <= fire | (pend_q & ~bus.ack[i]);
      end
    end

`ifdef DELAY_ARRAY_OVERRUN_EN
    logic err_q;

    // An expiry landing on an unacknowledged event is an overrun; only rst clears it.
    always_ff @(posedge clk) begin
      if (rst) begin
        err_q <= 1'b0;
      end else if (fire && pend_q && !bus.ack[i]) begin
        err_q <= 1'b1;
      end
    end

    assign bus.err[i] = err_q;
`else
    assign bus.err[i] = 1'b0;
`endif

    assign bus.sig[i]  = sig_q;
    assign bus.busy[i] = (state_q == RUN);
    assign bus.pend[i] = pend_q;
    assign run_d[i]    = (state_d == RUN);
  end

  // Built from next-state so idle_all changes on the same edge as busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_all_q <= 1'b1;
    end else begin
      idle_all_q <= ~|run_d;
    end
  end

  assign bus.idle_all = idle_all_q;

endmodule

// File: tb/tb_delay_array.sv
// tb_delay_array: directed scenarios plus randomized traffic, checked every cycle against an
// absolute-deadline model of the timer bank.
module tb_delay_array;
  localparam int NCH   = 4;
  localparam int CBITS = 12;
`ifdef DELAY_ARRAY_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  bit   chk_en  = 1'b0;

  delay_array_if #(.NCH(NCH), .CBITS(CBITS)) dif ();

  delay_array #(
    .NCH(NCH),
    .CBITS(CBITS),
    .PERIODIC_DEFAULT(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each running channel knows the absolute edge number of its next expiry.
  longint         cyc = 0;
  longint         m_next [NCH];
  int             m_per  [NCH];
  logic [NCH-1:0] m_act  = '0;
  logic [NCH-1:0] m_sig  = '0;
  logic [NCH-1:0] m_pend = '0;
  logic [NCH-1:0] m_err  = '0;
  logic [NCH-1:0] m_mode = '0;

  always @(posedge clk) begin
    logic [NCH-1:0] pend_old;
    logic [NCH-1:0] fire;
    cyc++;
    pend_old = m_pend;
    fire     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
        m_per[i] = 1;
      end else if (dif.abort[i]) begin
        m_act[i] = 1'b0;
      end else if (dif.start[i]) begin
        m_act[i]  = 1'b1;
        m_per[i]  = int'(dif.lim[i*CBITS +: CBITS]) + 1;
        m_next[i] = cyc + longint'(m_per[i]);
        m_mode[i] = dif.mode[i];
      end else if (m_act[i] && cyc == m_next[i]) begin
        fire[i] = 1'b1;
        if (m_mode[i]) m_next[i] = cyc + longint'(m_per[i]);
        else           m_act[i]  = 1'b0;
      end
    end
    if (rst) begin
      m_sig  = '0;
      m_pend = '0;
      m_err  = '0;
    end else begin
      m_sig  = fire;
      m_pend = fire | (pend_old & ~dif.ack);
      if (OVR) m_err = m_err | (fire & pend_old & ~dif.ack);
    end
  end

  logic [NCH-1:0] prev_sig = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic b2b;
      check("sig",      32'(dif.sig),      32'(m_sig));
      check("busy",     32'(dif.busy),     32'(m_act));
      check("pend",     32'(dif.pend),     32'(m_pend));
      check("err",      32'(dif.err),      32'(m_err));
      check("idle_all", 32'(dif.idle_all), 32'(~|m_act));
      b2b = 1'b0;
      for (int i = 0; i < NCH; i++)
        if (prev_sig[i] && dif.sig[i] && m_per[i] > 1) b2b = 1'b1;
      check("sig_b2b", 32'(b2b), 32'(0));
    end
    prev_sig = dif.sig;
  end

  task automatic set_lim(input int ch, input logic [CBITS-1:0] v);
    dif.lim[ch*CBITS +: CBITS] = v;
  endtask

  // Drives start for one edge; returns at the negedge after that edge (cycle 0).
  task automatic start_ch(input int ch, input logic [CBITS-1:0] l, input logic m);
    dif.start[ch] = 1'b1;
    dif.mode[ch]  = m;
    set_lim(ch, l);
    @(negedge clk);
    dif.start[ch] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          first_hit;
    int          hits;
    logic [15:0] mask;
    dif.start = '0;
    dif.abort = '0;
    dif.lim   = '0;
    dif.mode  = '0;
    dif.ack   = '0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("rst_sig",  32'(dif.sig),      32'(0));
    check("rst_busy", 32'(dif.busy),     32'(0));
    check("rst_idle", 32'(dif.idle_all), 32'(1));

    // Long one-shot on channel 0.
    start_ch(0, 12'd2500, 1'b0);
    first_hit = -1;
    hits      = 0;
    for (int k = 1; k <= 2505; k++) begin
      @(negedge clk);
      if (dif.sig[0]) begin
        hits++;
        if (first_hit < 0) first_hit = k;
      end
      if (k == 2500) check("a_busy_2500", 32'(dif.busy[0]), 32'(1));
      if (k == 2501) check("a_busy_2501", 32'(dif.busy[0]), 32'(0));
    end
    check("a_first_pulse", 32'(first_hit), 32'(2501));
    check("a_pulse_count", 32'(hits),      32'(1));
    check("a_pend",        32'(dif.pend[0]), 32'(1));
    check("a_idle_all",    32'(dif.idle_all), 32'(1));

    // Periodic channel 1, aborted during cycle 10.
    apply_reset();
    start_ch(1, 12'd3, 1'b1);
    mask = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (dif.sig[1]) mask[k] = 1'b1;
      if (k == 10) dif.abort[1] = 1'b1;
      if (k == 11) dif.abort[1] = 1'b0;
    end
    check("b_pulse_mask", 32'(mask), 32'h0110);
    check("b_busy",       32'(dif.busy[1]), 32'(0));

    // Channel 2: lim=0, start+abort collision, restart exactly at cnt==lim.
    apply_reset();
    start_ch(2, 12'd0, 1'b0);
    @(negedge clk);
    check("c_lim0_pulse", 32'(dif.sig[2]), 32'(1));
    @(negedge clk);
    check("c_lim0_after", 32'(dif.sig[2]), 32'(0));
    dif.start[2] = 1'b1;
    dif.abort[2] = 1'b1;
    @(negedge clk);
    dif.start[2] = 1'b0;
    dif.abort[2] = 1'b0;
    check("c_start_abort_busy", 32'(dif.busy[2]), 32'(0));
    start_ch(2, 12'd2, 1'b1);
    mask = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (dif.sig[2]) mask[k] = 1'b1;
      if (k == 2) dif.start[2] = 1'b1;
      if (k == 3) dif.start[2] = 1'b0;
    end
    check("c_restart_mask", 32'(mask), 32'h0040);
    dif.abort[2] = 1'b1;
    @(negedge clk);
    dif.abort[2] = 1'b0;

    // Channel 3 periodic lim=1 with ack held low: overrun at the second pulse.
    apply_reset();
    start_ch(3, 12'd1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) check("d_pulse1", 32'(dif.sig[3]), 32'(1));
      if (k == 3) check("d_err_3",  32'(dif.err[3]), 32'(0));
      if (k == 4) check("d_err_4",  32'(dif.err[3]), 32'(OVR));
      if (k == 8) check("d_err_8",  32'(dif.err[3]), 32'(OVR));
    end

    // All channels periodic, rst mid-count after two pulses each.
    apply_reset();
    for (int i = 0; i < NCH; i++) begin
      dif.start[i] = 1'b1;
      dif.mode[i]  = 1'b1;
      set_lim(i, 12'd20);
    end
    @(negedge clk);
    dif.start = '0;
    for (int k = 1; k <= 50; k++) @(negedge clk);
    check("e_pend_before", 32'(dif.pend), 32'hF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("e_sig",      32'(dif.sig),      32'(0));
    check("e_busy",     32'(dif.busy),     32'(0));
    check("e_pend",     32'(dif.pend),     32'(0));
    check("e_err",      32'(dif.err),      32'(0));
    check("e_idle_all", 32'(dif.idle_all), 32'(1));

    // Randomized traffic on all channels.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < NCH; i++) begin
        dif.start[i] = ($urandom_range(0, 15) == 0);
        dif.abort[i] = ($urandom_range(0, 39) == 0);
        dif.ack[i]   = ($urandom_range(0, 3) == 0);
        dif.mode[i]  = 1'($urandom_range(0, 1));
        set_lim(i, CBITS'($urandom_range(0, 20)));
      end
    end
    @(negedge clk);
    rst       = 1'b0;
    dif.start = '0;
    dif.abort = '0;
    dif.ack   = '0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
